uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter with an integrated baud divider and a small input FIFO. Byte sources write characters through a valid/ready handshake. The block serialises them LSB-first with a configurable frame: 5..DATA_W data bits, none/even/odd/mark parity, and 1 or 2 stop bits. It sits between the system-side data path and the tx pad, and it generates back-to-back frames with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 71 +++++++
 rtl/uart_tx_cfg.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART blocks: transmitter FSM state codes, parity modes
// and the shortest legal character length.
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t START  = 3'd1;
   localparam state_t DATA   = 3'd2;
   localparam state_t PARITY = 3'd3;
   localparam state_t STOP1  = 3'd4;
   localparam state_t STOP2  = 3'd5;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;
   localparam logic [1:0] PAR_MARK = 2'b11;

   localparam int MIN_DATA_LEN = 5;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO: head visible on pop_data with zero latency, one-cycle write.
// Pushes while full are dropped; ready is a registered not-full flag for the upstream handshake.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic                     ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_nxt;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok) begin
         count_nxt = count + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
         count_nxt = count - CNT_ONE;
      end
   end

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ready  <= 1'b1;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count <= count_nxt;
         ready <= (count_nxt != FULL_CNT);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: line falls 2 clocks after a push into an idle, empty block,
// frames run back-to-back while the FIFO holds data; s_ready drops when the FIFO is full.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DIV_W-1:0]              cfg_baud_div,
   input  logic [$clog2(DATA_W):0]       cfg_data_len,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   output logic                          tx_out,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int LEN_W = $clog2(DATA_W) + 1;

   state_t            state;
   state_t            state_nxt;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;

   logic [DIV_W-1:0]  div_cnt;
   logic [DIV_W-1:0]  div_q;
   logic [LEN_W-1:0]  bit_cnt;
   logic [LEN_W-1:0]  len_q;
   logic [DATA_W-1:0] shreg;
   logic              par_q;
   logic              par_en_q;
   logic              stop2_q;
   logic              tc;
   logic              frame_end;

   logic [LEN_W-1:0]  len_eff;
   logic [DIV_W-1:0]  div_eff;
   logic [DATA_W-1:0] data_masked;
   logic              par_bit;
   logic              tx_nxt;
   logic              busy_nxt;
   logic              done_nxt;

   assign fifo_push = s_valid && !fifo_full;

   uart_tx_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (s_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .ready     (s_ready),
      .count     (fifo_count)
   );

   // Frame parameters sampled from cfg_* only when a character is popped.
   always_comb begin
      if (cfg_data_len < LEN_W'(MIN_DATA_LEN) || cfg_data_len > LEN_W'(DATA_W)) begin
         len_eff = LEN_W'(DATA_W);
      end else begin
         len_eff = cfg_data_len;
      end
      div_eff = (cfg_baud_div == '0) ? DIV_W'(1) : cfg_baud_div;
      for (int i = 0; i < DATA_W; i++) begin
         data_masked[i] = (LEN_W'(i) < len_eff) ? fifo_dout[i] : 1'b0;
      end
      case (cfg_parity)
         PAR_EVEN: par_bit = ^data_masked;
         PAR_ODD:  par_bit = ~^data_masked;
         default:  par_bit = 1'b1;
      endcase
   end

   assign tc = (div_cnt == div_q - DIV_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (tc) state_nxt = DATA;
         end
         DATA: begin
            if (tc && bit_cnt == len_q - LEN_W'(1)) begin
               state_nxt = par_en_q ? PARITY : STOP1;
            end
         end
         PARITY: begin
            if (tc) state_nxt = STOP1;
         end
         STOP1: begin
            if (tc) begin
               if (stop2_q) state_nxt = STOP2;
               else         frame_end = 1'b1;
            end
         end
         STOP2: begin
            if (tc) frame_end = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      // Chain straight into the next start bit when more data is waiting.
      if (frame_end) begin
         if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = START;
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt  <= '0;
         div_q    <= DIV_W'(1);
         bit_cnt  <= '0;
         len_q    <= LEN_W'(DATA_W);
         shreg    <= '0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
      end else if (fifo_pop) begin
         div_cnt  <= '0;
         div_q    <= div_eff;
         bit_cnt  <= '0;
         len_q    <= len_eff;
         shreg    <= fifo_dout;
         par_q    <= par_bit;
         par_en_q <= (cfg_parity != PAR_NONE);
         stop2_q  <= cfg_stop2;
      end else if (state != IDLE) begin
         div_cnt <= tc ? '0 : div_cnt + DIV_W'(1);
         if (state == DATA && tc) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + LEN_W'(1);
         end
      end else begin
         div_cnt <= '0;
      end
   end

   always_comb begin
      case (state)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg[0];
         PARITY:  tx_nxt = par_q;
         default: tx_nxt = 1'b1;
      endcase
      busy_nxt = (state != IDLE);
      done_nxt = frame_end;
   end

   // Line outputs are registered, so they trail the state register by one clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_out  <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         tx_out  <= tx_nxt;
         tx_busy <= busy_nxt;
         tx_done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: accepted pushes queue an expected line waveform,
// a monitor captures each frame from its start bit and compares it.
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] cfg_baud_div;
   logic [3:0]  cfg_data_len;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        tx_out;
   logic        tx_busy;
   logic        tx_done;
   logic [2:0]  fifo_count;

   always #5 clk = ~clk;

   uart_tx_cfg dut (
      .clk          (clk),
      .reset        (reset),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .cfg_baud_div (cfg_baud_div),
      .cfg_data_len (cfg_data_len),
      .cfg_parity   (cfg_parity),
      .cfg_stop2    (cfg_stop2),
      .tx_out       (tx_out),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done),
      .fifo_count   (fifo_count)
   );

   typedef struct {
      logic [63:0] wave;
      int          total;
   } frame_t;

   frame_t exp_q[$];
   int     done_times[$];
   int     n_checks    = 0;
   int     n_fail      = 0;
   int     frames_done = 0;
   int     n_aborts    = 0;
   int     last_len    = 0;
   int     cyc         = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: the frame as a list of line bits, each repeated div clocks.
   function automatic frame_t make_frame(input logic [7:0] d);
      frame_t f;
      bit     seq[$];
      int     div;
      int     len;
      int     ones;
      div  = (cfg_baud_div == 16'd0) ? 1 : int'(cfg_baud_div);
      len  = (cfg_data_len < 4'd5 || cfg_data_len > 4'd8) ? 8 : int'(cfg_data_len);
      ones = 0;
      seq.push_back(1'b0);
      for (int i = 0; i < len; i++) begin
         seq.push_back(d[i]);
         ones += int'(d[i]);
      end
      case (cfg_parity)
         2'b01:   seq.push_back(ones % 2 == 1);
         2'b10:   seq.push_back(ones % 2 == 0);
         2'b11:   seq.push_back(1'b1);
         default: ;
      endcase
      seq.push_back(1'b1);
      if (cfg_stop2) seq.push_back(1'b1);
      f.wave  = '0;
      f.total = 0;
      foreach (seq[b]) begin
         for (int c = 0; c < div; c++) begin
            f.wave[f.total] = seq[b];
            f.total++;
         end
      end
      return f;
   endfunction

   initial begin : monitor
      frame_t      e;
      logic [63:0] wave;
      logic [63:0] done_w;
      logic [63:0] busy_w;
      bit          aborted;
      int          m;
      forever begin
         @(negedge clk);
         if (!reset && tx_out === 1'b0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: tx_out=0 at cycle %0d, required idle line 1", cyc);
               for (int t = 0; t < 64 && tx_done !== 1'b1; t++) @(negedge clk);
            end else begin
               e       = exp_q.pop_front();
               wave    = '0;
               done_w  = '0;
               busy_w  = '0;
               aborted = 1'b0;
               for (int k = 0; k < e.total; k++) begin
                  if (k > 0) @(negedge clk);
                  if (reset) begin
                     aborted = 1'b1;
                     break;
                  end
                  wave[k]   = tx_out;
                  done_w[k] = tx_done;
                  busy_w[k] = tx_busy;
               end
               if (aborted) begin
                  n_aborts++;
               end else begin
                  check("frame_wave", wave, e.wave);
                  check("frame_done", done_w, 64'(1) << (e.total - 1));
                  check("frame_busy", busy_w, (64'(1) << e.total) - 64'(1));
                  m = 0;
                  for (int k = 63; k >= 0; k--) if (done_w[k]) m = k + 1;
                  last_len = m;
                  done_times.push_back(cyc);
                  frames_done++;
               end
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] d);
      bit ok;
      ok      = 1'b0;
      s_data  = d;
      s_valid = 1'b1;
      for (int t = 0; t < 500 && !ok; t++) begin
         @(negedge clk);
         ok = s_ready;
         if (ok) exp_q.push_back(make_frame(d));
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      if (!ok) check("push_timeout", 64'(ok), 64'(1));
   endtask

   task automatic wait_frames(input int n, input string name);
      for (int t = 0; t < 3000 && frames_done < n; t++) @(posedge clk);
      #1;
      check(name, 64'(frames_done), 64'(n));
   endtask

   task automatic set_cfg(input int div, input int len, input int par, input bit stop2);
      cfg_baud_div = 16'(div);
      cfg_data_len = 4'(len);
      cfg_parity   = 2'(par);
      cfg_stop2    = stop2;
   endtask

   initial begin : stim
      int nacc;
      int base;
      int nb;
      bit acc;
      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = 8'h00;
      set_cfg(4, 8, 0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_out", 64'(tx_out), 64'(1));
      check("rst_busy", 64'(tx_busy), 64'(0));
      check("rst_done", 64'(tx_done), 64'(0));
      check("rst_count", 64'(fifo_count), 64'(0));
      check("rst_ready", 64'(s_ready), 64'(1));
      @(posedge clk);
      #1 reset = 1'b0;

      // 8N1 at div 4
      push_byte(8'hA5);
      wait_frames(1, "t1_frames");
      @(negedge clk);
      check("t1_busy_drop", 64'(tx_busy), 64'(0));
      check("t1_len", 64'(last_len), 64'(40));

      // 7E2 at div 2, bit 7 set but must not appear
      @(posedge clk); #1;
      set_cfg(2, 7, 1, 1'b1);
      push_byte(8'hB5);
      wait_frames(2, "t2_frames");
      check("t2_len", 64'(last_len), 64'(22));

      // 5O1 at div 1, two frames back-to-back
      set_cfg(1, 5, 2, 1'b0);
      push_byte(8'h1F);
      push_byte(8'hE1);
      wait_frames(4, "t3_frames");
      check("t3_len", 64'(last_len), 64'(8));
      check("t3_gap", 64'(done_times[3] - done_times[2]), 64'(8));

      // FIFO fill while draining
      set_cfg(3, 8, 0, 1'b0);
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         s_data  = 8'(8'h10 + i * 8'h11);
         s_valid = 1'b1;
         @(negedge clk);
         acc = s_ready;
         if (i == 5) begin
            check("t4_count_full", 64'(fifo_count), 64'(4));
            check("t4_ready_low", 64'(s_ready), 64'(0));
         end
         if (acc) begin
            exp_q.push_back(make_frame(s_data));
            nacc++;
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      check("t4_accepted", 64'(nacc), 64'(5));
      wait_frames(4 + nacc, "t4_frames");

      // Reset in the middle of the data bits
      set_cfg(4, 8, 0, 1'b0);
      base = frames_done;
      push_byte(8'h55);
      repeat (14) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("t5_tx_out", 64'(tx_out), 64'(1));
      check("t5_busy", 64'(tx_busy), 64'(0));
      check("t5_count", 64'(fifo_count), 64'(0));
      check("t5_abort", 64'(n_aborts), 64'(1));
      @(posedge clk); #1;
      push_byte(8'h3C);
      wait_frames(base + 1, "t5_frames");

      // Illegal divisor/length fall back; parity change mid-frame is ignored
      set_cfg(0, 3, 1, 1'b0);
      base = frames_done;
      push_byte(8'h96);
      repeat (3) @(posedge clk);
      #1 cfg_parity = 2'b10;
      wait_frames(base + 1, "t6_frames");
      check("t6_len", 64'(last_len), 64'(11));

      // Randomised batches; config only changes with the transmitter idle
      for (int b = 0; b < 20; b++) begin
         set_cfg($urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
         base = frames_done;
         nb   = $urandom_range(1, 6);
         for (int j = 0; j < nb; j++) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
            push_byte(8'($urandom));
         end
         wait_frames(base + nb, "rand_frames");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
